// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM access arbiter: RAM command codes and FSM states.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    RD_WAIT,
    RESP
  } state_e;

  // Command code for one beat of a transaction: address beat or data beat.
  function automatic logic [1:0] beat_cmd(input logic we, input logic data_beat);
    cmd_e c;
    if (we) c = data_beat ? WR_DATA : WR_ADDR;
    else    c = data_beat ? RD_DATA : RD_ADDR;
    return c;
  endfunction

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Requester-side and RAM-side bus of the RAM access arbiter.
interface ram_access_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int WIDTH = 8
);
  // Handshake: a requester holds req_valid (with we/addr/wdata stable) until it
  // sees its req_ready pulse; the transaction completes with one rsp_valid pulse
  // to that same requester. ram_rx_valid strobes each command beat on ram_din;
  // ram_tx_valid qualifies ram_dout. There is no backpressure from the RAM.
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_we;
  logic [N_REQ*WIDTH-1:0] req_addr;
  logic [N_REQ*WIDTH-1:0] req_wdata;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]       rsp_rdata;
  logic                   rsp_err;
  logic [WIDTH+1:0]       ram_din;
  logic                   ram_rx_valid;
  logic [WIDTH-1:0]       ram_dout;
  logic                   ram_tx_valid;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ram_dout, ram_tx_valid,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, ram_din, ram_rx_valid
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, ram_dout, ram_tx_valid,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, ram_din, ram_rx_valid
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last one served.
module rr_arbiter #(
  parameter int N_REQ = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  input  logic [IDX_W-1:0] advance_idx,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [IDX_W-1:0] last_q;

  // Resetting to the highest index makes requester 0 the first candidate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          last_q <= IDX_W'(N_REQ - 1);
    else if (advance) last_q <= advance_idx;
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      logic [IDX_W-1:0] idx;
      idx = IDX_W'((int'(last_q) + k) % N_REQ);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
    grant = grant_valid ? (ONE << grant_idx) : '0;
  end
endmodule

// File: rtl/ram_access_arbiter.sv
// Shares a single-port SPI RAM between N_REQ word requesters, expanding each
// accepted request into an address beat followed by its data beat.
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int WIDTH      = 8,
  parameter int RD_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_access_arbiter_if.slave  bus,
  output logic                 busy,
  output state_e               dbg_state
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [IDX_W-1:0] owner_q;
  logic             we_q;
  logic [WIDTH-1:0] addr_q, wdata_q, rdata_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             accept;
  logic             timeout_hit;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk         (clk),
    .rst         (rst),
    .req         (bus.req_valid),
    .advance     (state_q == RESP),
    .advance_idx (owner_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Gated by rst so nothing is accepted while reset is held.
  assign accept      = (state_q == IDLE) && grant_valid && !rst;
  assign timeout_hit = (cnt_q == CNT_W'(RD_TIMEOUT - 1));

  always_comb begin
    state_d          = state_q;
    bus.ram_rx_valid = 1'b0;
    bus.ram_din      = '0;
    bus.rsp_valid    = '0;
    bus.req_ready    = accept ? grant : '0;
    case (state_q)
      IDLE:    if (accept) state_d = ADDR;
      ADDR: begin
        bus.ram_rx_valid = 1'b1;
        bus.ram_din      = {beat_cmd(we_q, 1'b0), addr_q};
        state_d          = DATA;
      end
      DATA: begin
        bus.ram_rx_valid = 1'b1;
        bus.ram_din      = {beat_cmd(we_q, 1'b1), (we_q ? wdata_q : {WIDTH{1'b0}})};
        state_d          = we_q ? RESP : RD_WAIT;
      end
      RD_WAIT: if (bus.ram_tx_valid || timeout_hit) state_d = RESP;
      RESP: begin
        bus.rsp_valid = ONE << owner_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (accept) begin
          owner_q <= grant_idx;
          we_q    <= bus.req_we[grant_idx];
          addr_q  <= bus.req_addr[grant_idx*WIDTH +: WIDTH];
          wdata_q <= bus.req_wdata[grant_idx*WIDTH +: WIDTH];
        end
        DATA: cnt_q <= '0;
        RD_WAIT: begin
          if (bus.ram_tx_valid) begin
            rdata_q <= bus.ram_dout;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign busy          = (state_q != IDLE);
  assign dbg_state     = state_q;
endmodule
